// File: rtl/dram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dram_pkg
//  Description : Shared types and constants for the DRAM request path:
//                issue-sequencer state encoding, command encoding and the
//                request entry layout used by the controller user port.
//  Revision    : 1.0 - initial release
// ============================================================================
package dram_pkg;

  // Widths of the controller user port; the request queue follows these.
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } issue_state_e;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } dram_req_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : sync_fifo
//  Description : Single-clock FIFO with separate occupancy count. DEPTH must
//                be a power of two so the pointers wrap by natural overflow.
//                A push while full is refused even if a pop happens the same
//                cycle; the head entry is presented combinationally.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic             u_clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LVL_W-1:0] count_o
);

  localparam int PTR_W = LVL_W - 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == LVL_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // Next pointer and count values from the accepted push/pop pair
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers
  always_ff @(posedge u_clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until written
  always_ff @(posedge u_clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule
`default_nettype wire

// File: rtl/dram_req_queue.sv
`default_nettype none
// ============================================================================
//  Module      : dram_req_queue
//  Description : Request queue and in-order issue sequencer in front of the
//                DRAM controller user port. Requests are buffered in a FIFO,
//                issued one at a time, and read data is returned through a
//                single-entry response register with backpressure. Reads are
//                held back while a response is still pending so read data can
//                never be overwritten; writes are not gated by the response.
//  Revision    : 1.0 - initial release
// ============================================================================
module dram_req_queue
  import dram_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = dram_pkg::ADDR_W,
  parameter int DATA_W = dram_pkg::DATA_W,
  parameter int LVL_W  = $clog2(DEPTH + 1)
) (
  input  logic              u_clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [LVL_W-1:0]  q_level,
  output logic              ctl_en,
  output logic              ctl_cmd,
  output logic [ADDR_W-1:0] ctl_addr,
  output logic [DATA_W-1:0] ctl_wdata,
  input  logic              ctl_cmd_ack,
  input  logic              ctl_busy,
  input  logic [DATA_W-1:0] ctl_rdata,
  input  logic              ctl_rdata_valid
);

  localparam int ENTRY_W = $bits(dram_req_t);

  dram_req_t         push_entry;
  dram_req_t         head_entry;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LVL_W-1:0]  fifo_count;
  logic              fifo_pop;
  logic              issue_ok;
  logic              rsp_load;

  issue_state_e      state_q;
  logic              ctl_en_q;
  logic              ctl_cmd_q;
  logic [ADDR_W-1:0] ctl_addr_q;
  logic [DATA_W-1:0] ctl_wdata_q;
  logic              pending_rd_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;

  assign push_entry = '{write: req_write, addr: req_addr, wdata: req_wdata};

  // The entry under issue stays in the FIFO until the controller acknowledges it
  assign fifo_pop = (state_q == S_REQ) && ctl_cmd_ack;

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .u_clk   (u_clk),
    .rst_n   (rst_n),
    .push_i  (req_valid),
    .data_i  (push_entry),
    .pop_i   (fifo_pop),
    .data_o  (head_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // A read may only start once the previous read data has been taken
  assign issue_ok = !fifo_empty && !ctl_busy &&
                    ((head_entry.write == CMD_WRITE) || !rsp_valid_q);

  assign rsp_load = (state_q == S_WAIT) && pending_rd_q && ctl_rdata_valid;

  // Issue sequencer: latch head, hold command until ack, wait out the controller
  always_ff @(posedge u_clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      ctl_en_q     <= 1'b0;
      ctl_cmd_q    <= CMD_READ;
      ctl_addr_q   <= '0;
      ctl_wdata_q  <= '0;
      pending_rd_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (issue_ok) begin
            state_q     <= S_REQ;
            ctl_en_q    <= 1'b1;
            ctl_cmd_q   <= head_entry.write;
            ctl_addr_q  <= head_entry.addr;
            ctl_wdata_q <= head_entry.wdata;
          end
        end
        S_REQ: begin
          if (ctl_cmd_ack) begin
            state_q      <= S_WAIT;
            ctl_en_q     <= 1'b0;
            pending_rd_q <= (ctl_cmd_q == CMD_READ);
          end
        end
        S_WAIT: begin
          if (ctl_rdata_valid && pending_rd_q) begin
            pending_rd_q <= 1'b0;
          end else if (!ctl_busy && !pending_rd_q) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          ctl_en_q <= 1'b0;
        end
      endcase
    end
  end

  // Single-entry response register; a new load wins over a same-cycle consume
  always_ff @(posedge u_clk) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (rsp_valid_q && rsp_ready) rsp_valid_q <= 1'b0;
      if (rsp_load) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= ctl_rdata;
      end
    end
  end

  assign req_ready = !fifo_full;
  assign q_level   = fifo_count;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign ctl_en    = ctl_en_q;
  assign ctl_cmd   = ctl_cmd_q;
  assign ctl_addr  = ctl_addr_q;
  assign ctl_wdata = ctl_wdata_q;

endmodule
`default_nettype wire
